// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage types: FSM encoding, register-address width, word-alignment helper.
package mem_access_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus; master = MEM stage, slave = memory.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              DmemReq;
    logic              DmemWe;
    logic [DATA_W-1:0] DmemAddr;
    logic [DATA_W-1:0] DmemWData;
    logic              DmemAck;
    logic [DATA_W-1:0] DmemRData;

    modport master (
        output DmemReq, DmemWe, DmemAddr, DmemWData,
        input  DmemAck, DmemRData
    );

    modport slave (
        input  DmemReq, DmemWe, DmemAddr, DmemWData,
        output DmemAck, DmemRData
    );
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads every cycle; bubble zeroes all fields.
// Latency one cycle, no backpressure of its own (the writeback side never stalls).
module mem_wb_reg
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bubble,
    input  logic                  reg_write_in,
    input  logic                  memto_reg_in,
    input  logic [DATA_W-1:0]     alu_out_in,
    input  logic [DATA_W-1:0]     read_data_in,
    input  logic [REG_ADDR_W-1:0] write_reg_in,
    input  logic                  stop_in,
    input  logic                  misalign_in,
    input  logic                  bus_err_in,
    output logic                  reg_write_w,
    output logic                  memto_reg_w,
    output logic [DATA_W-1:0]     alu_out_w,
    output logic [DATA_W-1:0]     read_data_w,
    output logic [REG_ADDR_W-1:0] write_reg_w,
    output logic                  stop_w,
    output logic                  misalign_w,
    output logic                  bus_err_w
);

    logic                  reg_write_d, reg_write_q;
    logic                  memto_reg_d, memto_reg_q;
    logic [DATA_W-1:0]     alu_out_d, alu_out_q;
    logic [DATA_W-1:0]     read_data_d, read_data_q;
    logic [REG_ADDR_W-1:0] write_reg_d, write_reg_q;
    logic                  stop_d, stop_q;
    logic                  misalign_d, misalign_q;
    logic                  bus_err_d, bus_err_q;

    always_comb begin
        reg_write_d = reg_write_in;
        memto_reg_d = memto_reg_in;
        alu_out_d   = alu_out_in;
        read_data_d = read_data_in;
        write_reg_d = write_reg_in;
        stop_d      = stop_in;
        misalign_d  = misalign_in;
        bus_err_d   = bus_err_in;
        if (bubble) begin
            reg_write_d = 1'b0;
            memto_reg_d = 1'b0;
            alu_out_d   = '0;
            read_data_d = '0;
            write_reg_d = '0;
            stop_d      = 1'b0;
            misalign_d  = 1'b0;
            bus_err_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
            alu_out_q   <= '0;
            read_data_q <= '0;
            write_reg_q <= '0;
            stop_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            reg_write_q <= reg_write_d;
            memto_reg_q <= memto_reg_d;
            alu_out_q   <= alu_out_d;
            read_data_q <= read_data_d;
            write_reg_q <= write_reg_d;
            stop_q      <= stop_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign reg_write_w = reg_write_q;
    assign memto_reg_w = memto_reg_q;
    assign alu_out_w   = alu_out_q;
    assign read_data_w = read_data_q;
    assign write_reg_w = write_reg_q;
    assign stop_w      = stop_q;
    assign misalign_w  = misalign_q;
    assign bus_err_w   = bus_err_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory access over req/ack, results into MEM/WB; 1 cycle, +N per wait state.
// StallM holds upstream while an access waits for ack; MEM_TIMEOUT_EN adds a bus-error timeout.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic                  LoadM,
    input  logic [DATA_W-1:0]     ALUOutM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [DATA_W-1:0]     WriteDataM,
    input  logic                  StopM,
    output logic                  StallM,
    mem_access_stage_if.master    dmem,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [DATA_W-1:0]     ALUOutW,
    output logic [DATA_W-1:0]     ReadDataW,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic                  StopW,
    output logic                  MisalignW,
    output logic                  BusErrW,
    output logic                  Halted
);

    state_t            state_d, state_q;
    logic [DATA_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              we_d, we_q;
    logic              halted_d, halted_q;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_d, tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    logic                  memop;
    logic                  aligned;
    logic                  bubble;
    logic                  w_reg_write;
    logic                  w_memto_reg;
    logic [DATA_W-1:0]     w_read_data;
    logic                  w_misalign;
    logic                  w_bus_err;

    assign memop   = LoadM | MemWriteM;
    assign aligned = is_word_aligned(ALUOutM[1:0]);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
`ifdef MEM_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif
        dmem.DmemReq   = 1'b0;
        dmem.DmemWe    = 1'b0;
        dmem.DmemAddr  = '0;
        dmem.DmemWData = '0;
        StallM         = 1'b0;
        bubble         = 1'b0;
        w_reg_write    = RegWriteM;
        w_memto_reg    = MemtoRegM;
        w_read_data    = '0;
        w_misalign     = 1'b0;
        w_bus_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop && !aligned) begin
                    w_reg_write = 1'b0;
                    w_memto_reg = 1'b0;
                    w_misalign  = 1'b0 | 1'b1;
                end else if (memop) begin
                    dmem.DmemReq   = 1'b1;
                    dmem.DmemWe    = MemWriteM;
                    dmem.DmemAddr  = ALUOutM;
                    dmem.DmemWData = WriteDataM;
                    if (dmem.DmemAck) begin
                        // Store wins over load when both flags are set.
                        w_reg_write = RegWriteM & ~MemWriteM;
                        w_read_data = MemWriteM ? '0 : dmem.DmemRData;
                    end else begin
                        StallM  = 1'b1;
                        bubble  = 1'b1;
                        state_d = BUSY;
                        addr_d  = ALUOutM;
                        wdata_d = WriteDataM;
                        we_d    = MemWriteM;
`ifdef MEM_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            BUSY: begin
                dmem.DmemReq   = 1'b1;
                dmem.DmemWe    = we_q;
                dmem.DmemAddr  = addr_q;
                dmem.DmemWData = wdata_q;
                if (dmem.DmemAck) begin
                    state_d     = IDLE;
                    w_reg_write = RegWriteM & ~we_q;
                    w_read_data = we_q ? '0 : dmem.DmemRData;
`ifdef MEM_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    state_d     = IDLE;
                    w_reg_write = 1'b0;
                    w_memto_reg = 1'b0;
                    w_bus_err   = 1'b1;
`endif
                end else begin
                    StallM = 1'b1;
                    bubble = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    tmo_d  = tmo_q + 1'b1;
`endif
                end
            end
        endcase

        // Reset must drop the request in the very cycle it is sampled.
        if (RST) begin
            dmem.DmemReq = 1'b0;
            StallM       = 1'b0;
            state_d      = IDLE;
        end
    end

    assign halted_d = halted_q | (StopM & ~bubble);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            halted_q <= halted_d;
`ifdef MEM_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign Halted = halted_q;

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .CLK          (CLK),
        .RST          (RST),
        .bubble       (bubble),
        .reg_write_in (w_reg_write),
        .memto_reg_in (w_memto_reg),
        .alu_out_in   (ALUOutM),
        .read_data_in (w_read_data),
        .write_reg_in (WriteRegM),
        .stop_in      (StopM),
        .misalign_in  (w_misalign),
        .bus_err_in   (w_bus_err),
        .reg_write_w  (RegWriteW),
        .memto_reg_w  (MemtoRegW),
        .alu_out_w    (ALUOutW),
        .read_data_w  (ReadDataW),
        .write_reg_w  (WriteRegW),
        .stop_w       (StopW),
        .misalign_w   (MisalignW),
        .bus_err_w    (BusErrW)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; timeout scenario runs only with MEM_TIMEOUT_EN.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  RegWriteM, MemtoRegM, MemWriteM, LoadM, StopM;
    logic [31:0]           ALUOutM, WriteDataM;
    logic [REG_ADDR_W-1:0] WriteRegM;
    logic                  StallM;
    logic                  RegWriteW, MemtoRegW, StopW, MisalignW, BusErrW, Halted;
    logic [31:0]           ALUOutW, ReadDataW;
    logic [REG_ADDR_W-1:0] WriteRegW;

    int errors = 0;
    int checks = 0;

    mem_access_stage_if #(.DATA_W(32)) dmem_if ();

    mem_access_stage #(.DATA_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .LoadM(LoadM),
        .ALUOutM(ALUOutM), .WriteRegM(WriteRegM), .WriteDataM(WriteDataM), .StopM(StopM),
        .StallM(StallM), .dmem(dmem_if),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
        .WriteRegW(WriteRegW), .StopW(StopW), .MisalignW(MisalignW), .BusErrW(BusErrW),
        .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_nop();
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; LoadM = 0; StopM = 0;
        ALUOutM = 0; WriteDataM = 0; WriteRegM = 0;
    endtask

    task automatic test_reset();
        RST = 1; set_nop();
        dmem_if.DmemAck = 0; dmem_if.DmemRData = 0;
        LoadM = 1; RegWriteM = 1; StopM = 1; ALUOutM = 32'h40;
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_if.DmemReq); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallM); end
        tick(); tick();
        checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", RegWriteW); end
        checks++; if (ALUOutW !== 32'h0) begin errors++; $display("FAIL reset_aluout: got %h want 0", ALUOutW); end
        checks++; if (StopW !== 1'b0) begin errors++; $display("FAIL reset_stopw: got %b want 0", StopW); end
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", Halted); end
        set_nop(); RST = 0;
        tick();
    endtask

    task automatic test_alu();
        set_nop(); RegWriteM = 1; ALUOutM = 32'h1234; WriteRegM = 5;
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b0) begin errors++; $display("FAIL alu_req: got %b want 0", dmem_if.DmemReq); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", StallM); end
        tick();
        checks++; if (RegWriteW !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b want 1", RegWriteW); end
        checks++; if (ALUOutW !== 32'h1234) begin errors++; $display("FAIL alu_aluout: got %h want 1234", ALUOutW); end
        checks++; if (WriteRegW !== 5'd5) begin errors++; $display("FAIL alu_writereg: got %0d want 5", WriteRegW); end
        checks++; if (ReadDataW !== 32'h0) begin errors++; $display("FAIL alu_readdata: got %h want 0", ReadDataW); end
    endtask

    task automatic test_load_zero_wait();
        set_nop(); LoadM = 1; MemtoRegM = 1; RegWriteM = 1; ALUOutM = 32'h40; WriteRegM = 7;
        dmem_if.DmemAck = 1; dmem_if.DmemRData = 32'hDEADBEEF;
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b1) begin errors++; $display("FAIL ld0_req: got %b want 1", dmem_if.DmemReq); end
        checks++; if (dmem_if.DmemWe !== 1'b0) begin errors++; $display("FAIL ld0_we: got %b want 0", dmem_if.DmemWe); end
        checks++; if (dmem_if.DmemAddr !== 32'h40) begin errors++; $display("FAIL ld0_addr: got %h want 40", dmem_if.DmemAddr); end
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL ld0_stall: got %b want 0", StallM); end
        tick();
        dmem_if.DmemAck = 0; set_nop();
        checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL ld0_rdata: got %h want deadbeef", ReadDataW); end
        checks++; if (MemtoRegW !== 1'b1) begin errors++; $display("FAIL ld0_memtoreg: got %b want 1", MemtoRegW); end
        checks++; if (RegWriteW !== 1'b1 || WriteRegW !== 5'd7) begin errors++; $display("FAIL ld0_dest: got %b/%0d want 1/7", RegWriteW, WriteRegW); end
    endtask

    task automatic test_store_wait();
        int stall_cnt = 0;
        set_nop(); MemWriteM = 1; RegWriteM = 1; ALUOutM = 32'h80; WriteDataM = 32'hA5A5A5A5; WriteRegM = 3;
        dmem_if.DmemAck = 0; dmem_if.DmemRData = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (StallM === 1'b1) stall_cnt++;
            checks++; if (dmem_if.DmemReq !== 1'b1 || dmem_if.DmemWe !== 1'b1) begin errors++; $display("FAIL st_req[%0d]: got %b%b want 11", i, dmem_if.DmemReq, dmem_if.DmemWe); end
            checks++; if (dmem_if.DmemAddr !== 32'h80) begin errors++; $display("FAIL st_addr[%0d]: got %h want 80", i, dmem_if.DmemAddr); end
            checks++; if (dmem_if.DmemWData !== 32'hA5A5A5A5) begin errors++; $display("FAIL st_wdata[%0d]: got %h want a5a5a5a5", i, dmem_if.DmemWData); end
            tick();
            checks++; if ({RegWriteW, StopW, MisalignW, BusErrW} !== 4'b0) begin errors++; $display("FAIL st_bubble[%0d]: got %b want 0000", i, {RegWriteW, StopW, MisalignW, BusErrW}); end
            WriteDataM = 32'h0;
        end
        dmem_if.DmemAck = 1;
        settle();
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL st_ack_stall: got %b want 0", StallM); end
        checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL st_stall_cycles: got %0d want 3", stall_cnt); end
        checks++; if (dmem_if.DmemWData !== 32'hA5A5A5A5) begin errors++; $display("FAIL st_wdata_ack: got %h want a5a5a5a5", dmem_if.DmemWData); end
        tick();
        dmem_if.DmemAck = 0;
        checks++; if (RegWriteW !== 1'b0 || BusErrW !== 1'b0) begin errors++; $display("FAIL st_done: got regw=%b buserr=%b want 0/0", RegWriteW, BusErrW); end
        checks++; if (ALUOutW !== 32'h80 || ReadDataW !== 32'h0) begin errors++; $display("FAIL st_done_data: got %h/%h want 80/0", ALUOutW, ReadDataW); end
        checks++; if (WriteRegW !== 5'd3) begin errors++; $display("FAIL st_done_wreg: got %0d want 3", WriteRegW); end
        set_nop();
    endtask

    task automatic test_misalign();
        set_nop(); LoadM = 1; RegWriteM = 1; MemtoRegM = 1; ALUOutM = 32'h42; WriteRegM = 9;
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", dmem_if.DmemReq, StallM); end
        tick();
        checks++; if (MisalignW !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", MisalignW); end
        checks++; if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0) begin errors++; $display("FAIL mis_ctrl: got %b%b want 00", RegWriteW, MemtoRegW); end
        checks++; if (ALUOutW !== 32'h42 || WriteRegW !== 5'd9) begin errors++; $display("FAIL mis_fields: got %h/%0d want 42/9", ALUOutW, WriteRegW); end
        set_nop();
        tick();
        checks++; if (MisalignW !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", MisalignW); end
    endtask

    task automatic test_both_flags();
        set_nop(); LoadM = 1; MemWriteM = 1; RegWriteM = 1; ALUOutM = 32'h10; WriteDataM = 32'h77;
        dmem_if.DmemAck = 1; dmem_if.DmemRData = 32'h99;
        settle();
        checks++; if (dmem_if.DmemWe !== 1'b1) begin errors++; $display("FAIL both_we: got %b want 1", dmem_if.DmemWe); end
        tick();
        dmem_if.DmemAck = 0;
        checks++; if (RegWriteW !== 1'b0 || ReadDataW !== 32'h0) begin errors++; $display("FAIL both_w: got %b/%h want 0/0", RegWriteW, ReadDataW); end
        set_nop();
    endtask

    task automatic test_halt();
        set_nop(); StopM = 1; dmem_if.DmemAck = 1;
        tick();
        dmem_if.DmemAck = 0;
        checks++; if (StopW !== 1'b1 || Halted !== 1'b1) begin errors++; $display("FAIL halt_set: got stop=%b halted=%b want 1/1", StopW, Halted); end
        checks++; if (ReadDataW !== 32'h0) begin errors++; $display("FAIL halt_noreq_ack: got %h want 0", ReadDataW); end
        StopM = 0;
        tick();
        checks++; if (StopW !== 1'b0 || Halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got stop=%b halted=%b want 0/1", StopW, Halted); end
    endtask

    task automatic test_reset_mid();
        set_nop(); LoadM = 1; RegWriteM = 1; ALUOutM = 32'h100; WriteRegM = 4; dmem_if.DmemAck = 0;
        tick();
        settle();
        checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", StallM); end
        RST = 1;
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL rm_drop: got req=%b stall=%b want 0/0", dmem_if.DmemReq, StallM); end
        tick();
        RST = 0; set_nop();
        checks++; if (ALUOutW !== 32'h0 || WriteRegW !== 5'd0 || Halted !== 1'b0) begin errors++; $display("FAIL rm_wzero: got %h/%0d/%b want 0/0/0", ALUOutW, WriteRegW, Halted); end
        dmem_if.DmemAck = 1; dmem_if.DmemRData = 32'hFFFFFFFF;
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL rm_idle: got req=%b stall=%b want 0/0", dmem_if.DmemReq, StallM); end
        tick();
        dmem_if.DmemAck = 0;
        checks++; if (ReadDataW !== 32'h0 || RegWriteW !== 1'b0) begin errors++; $display("FAIL rm_late_ack: got %h/%b want 0/0", ReadDataW, RegWriteW); end
    endtask

    task automatic test_back_to_back();
        set_nop(); LoadM = 1; MemtoRegM = 1; RegWriteM = 1; ALUOutM = 32'h44; WriteRegM = 2; dmem_if.DmemAck = 0;
        settle();
        checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b want 1", StallM); end
        tick();
        dmem_if.DmemAck = 1; dmem_if.DmemRData = 32'hCAFEF00D;
        settle();
        checks++; if (StallM !== 1'b0 || dmem_if.DmemAddr !== 32'h44) begin errors++; $display("FAIL b2b_ack: got stall=%b addr=%h want 0/44", StallM, dmem_if.DmemAddr); end
        tick();
        dmem_if.DmemAck = 0; set_nop(); RegWriteM = 1; ALUOutM = 32'h55; WriteRegM = 6;
        checks++; if (ReadDataW !== 32'hCAFEF00D || RegWriteW !== 1'b1 || WriteRegW !== 5'd2) begin errors++; $display("FAIL b2b_load: got %h/%b/%0d want cafef00d/1/2", ReadDataW, RegWriteW, WriteRegW); end
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b0) begin errors++; $display("FAIL b2b_alu_req: got %b want 0", dmem_if.DmemReq); end
        tick();
        checks++; if (ALUOutW !== 32'h55 || ReadDataW !== 32'h0) begin errors++; $display("FAIL b2b_alu: got %h/%h want 55/0", ALUOutW, ReadDataW); end
        set_nop();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        set_nop(); LoadM = 1; RegWriteM = 1; StopM = 1; ALUOutM = 32'h20; dmem_if.DmemAck = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL tmo_stall[%0d]: got %b want 1", i, StallM); end
            tick();
        end
        settle();
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL tmo_drop: got %b want 0", StallM); end
        tick();
        checks++; if (BusErrW !== 1'b1 || StopW !== 1'b1 || RegWriteW !== 1'b0) begin errors++; $display("FAIL tmo_w: got buserr=%b stop=%b regw=%b want 1/1/0", BusErrW, StopW, RegWriteW); end
        checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL tmo_halted: got %b want 1", Halted); end
        set_nop();
        settle();
        checks++; if (dmem_if.DmemReq !== 1'b0) begin errors++; $display("FAIL tmo_idle_req: got %b want 0", dmem_if.DmemReq); end
        tick();
        checks++; if (BusErrW !== 1'b0 || Halted !== 1'b1) begin errors++; $display("FAIL tmo_after: got buserr=%b halted=%b want 0/1", BusErrW, Halted); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_zero_wait();
        test_store_wait();
        test_misalign();
        test_both_flags();
        test_halt();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
